// File: rtl/dmem_sized_if.sv
// Request/response bundle between the MEM stage and the sized data memory.
// The master drives access requests and clr_req; the slave returns load data, strobes and busy.
interface dmem_sized_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  mem_write;
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic                  mem_misalign;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output mem_write, mem_read, mem_addr, mem_size, mem_unsigned, mem_wdata, clr_req,
    input  mem_rdata, mem_rvalid, mem_misalign, busy
  );

  modport slave (
    input  mem_write, mem_read, mem_addr, mem_size, mem_unsigned, mem_wdata, clr_req,
    output mem_rdata, mem_rvalid, mem_misalign, busy
  );
endinterface

// File: rtl/dmem_sized.sv
// Byte/half/word data memory with load extension, misalignment flagging and a
// one-word-per-cycle clear sequencer that runs after reset or on clr_req.
module dmem_sized #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int WORD_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_sized_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                state_q;
  logic [AW-1:0]         cnt_q;
  logic                  busy_q;
  logic                  rvalid_q;
  logic                  misalign_q;
  logic                  zero_q;
  logic [1:0]            size_q;
  logic [1:0]            lane_q;
  logic                  uns_q;
  logic [WORD_WIDTH-1:0] rd_word_q;
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];

  logic                  idle;
  logic [AW-1:0]         word_idx;
  logic                  mis;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  arr_we;
  logic                  arr_re;
  logic [AW-1:0]         arr_idx;
  logic [3:0]            arr_be;
  logic [WORD_WIDTH-1:0] arr_wd;
  logic [WORD_WIDTH-1:0] rdata_fmt;
  logic                  unused_addr;

  assign idle     = (state_q == S_IDLE);
  assign word_idx = bus.mem_addr[AW+1:2];
  assign mis      = ((bus.mem_size == 2'b01) && bus.mem_addr[0])
                  || ((bus.mem_size == 2'b10) && (bus.mem_addr[1:0] != 2'b00))
                  || (bus.mem_size == 2'b11);
  assign wr_acc   = idle && bus.mem_write;
  assign rd_acc   = idle && bus.mem_read && !bus.mem_write;

  // The array must stay untouched while reset is held, even though the FSM sits in CLEAR.
  assign arr_we  = rst && (!idle || (wr_acc && !mis));
  assign arr_re  = rd_acc && !mis;
  assign arr_idx = idle ? word_idx : cnt_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       store_be;
    logic [7:0] store_byte;

    assign store_be = (bus.mem_size == 2'b10)
                   || ((bus.mem_size == 2'b01) && (bus.mem_addr[1] == LANE[1]))
                   || ((bus.mem_size == 2'b00) && (bus.mem_addr[1:0] == LANE));

    // Right-aligned store data is replicated so every addressed lane sees its own slice.
    always_comb begin
      store_byte = bus.mem_wdata[8*gi +: 8];
      case (bus.mem_size)
        2'b00:   store_byte = bus.mem_wdata[7:0];
        2'b01:   store_byte = bus.mem_wdata[8*(gi % 2) +: 8];
        default: store_byte = bus.mem_wdata[8*gi +: 8];
      endcase
    end

    assign arr_be[gi]         = idle ? store_be : 1'b1;
    assign arr_wd[8*gi +: 8]  = idle ? store_byte : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int i = 0; i < 4; i++) begin
        if (arr_be[i]) mem_q[arr_idx][8*i +: 8] <= arr_wd[8*i +: 8];
      end
    end
    if (arr_re) rd_word_q <= mem_q[arr_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      busy_q     <= 1'b1;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      zero_q     <= 1'b1;
      size_q     <= 2'b10;
      lane_q     <= 2'b00;
      uns_q      <= 1'b0;
    end else begin
      rvalid_q   <= rd_acc;
      misalign_q <= (wr_acc || rd_acc) && mis;
      if (rd_acc) begin
        zero_q <= mis;
        size_q <= bus.mem_size;
        lane_q <= bus.mem_addr[1:0];
        uns_q  <= bus.mem_unsigned;
      end
      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.clr_req) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_CLEAR;
          cnt_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Load shaping works off the captured word plus the request attributes latched with it,
  // so the result holds until the next load response.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = rd_word_q[8*lane_q +: 8];
    h = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (size_q)
      2'b00:   rdata_fmt = uns_q ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   rdata_fmt = uns_q ? {16'h0, h} : {{16{h[15]}}, h};
      default: rdata_fmt = rd_word_q;
    endcase
  end

  assign bus.mem_rdata    = zero_q ? '0 : rdata_fmt;
  assign bus.mem_rvalid   = rvalid_q;
  assign bus.mem_misalign = misalign_q;
  assign bus.busy         = busy_q;

  assign unused_addr = ^bus.mem_addr[ADDR_WIDTH-1:AW+2];
endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: clear sequencing, sized stores/loads, misalignment,
// write priority, address wrap, clr_req handling and reset during a clear.
module tb_dmem_sized;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  dmem_sized_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

  dmem_sized #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .WORD_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.mem_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_size     = 2'b10;
    bus.mem_unsigned = 1'b0;
    bus.mem_wdata    = '0;
    bus.clr_req      = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          output logic mis);
    bus.mem_write = 1'b1;
    bus.mem_addr  = a;
    bus.mem_size  = sz;
    bus.mem_wdata = d;
    cyc();
    mis = bus.mem_misalign;
    idle_in();
    $display("store addr=%h size=%0d data=%h misalign=%0b", a, sz, d, mis);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         output logic [31:0] rd, output logic rv, output logic mis);
    bus.mem_read     = 1'b1;
    bus.mem_addr     = a;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
    cyc();
    rd  = bus.mem_rdata;
    rv  = bus.mem_rvalid;
    mis = bus.mem_misalign;
    idle_in();
    $display("load  addr=%h size=%0d uns=%0b rdata=%h rvalid=%0b misalign=%0b", a, sz, uns, rd, rv, mis);
  endtask

  // Counts edges until busy drops (bounded). With poke set, a load of 0x40 is held and a
  // clr_req is pulsed mid-clear; any response strobe seen meanwhile is reported.
  task automatic count_busy(input logic poke, output int n, output logic strobe);
    n = 0;
    strobe = 1'b0;
    do begin
      if (poke) begin
        bus.mem_read = 1'b1;
        bus.mem_addr = 32'h40;
        bus.mem_size = 2'b10;
        bus.clr_req  = (n == 3);
      end
      cyc();
      n++;
      strobe = strobe | bus.mem_rvalid | bus.mem_misalign;
    end while (bus.busy && n < 500);
    idle_in();
    $display("clear done after %0d cycles", n);
  endtask

  initial begin
    logic [31:0] rd;
    logic        rv;
    logic        mis;
    int          n;
    logic        strobe;

    n_checks = 0;
    n_err    = 0;
    idle_in();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_rvalid", 32'(bus.mem_rvalid), 32'd0);
    chk("rst_misalign", 32'(bus.mem_misalign), 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    rst = 1'b1;
    count_busy(1'b0, n, strobe);
    chk("init_clear_len", 32'(n), 32'(DEPTH));

    do_load(32'h0, 2'b10, 1'b0, rd, rv, mis);
    chk("ld_w0", rd, 32'h0);
    chk("ld_w0_rvalid", 32'(rv), 32'd1);
    do_load(32'(4 * (DEPTH - 1)), 2'b10, 1'b0, rd, rv, mis);
    chk("ld_wlast", rd, 32'h0);

    do_store(32'h10, 2'b10, 32'h11223344, mis);
    do_store(32'h11, 2'b00, 32'hFFFF_FFAA, mis);
    do_store(32'h12, 2'b01, 32'h0000_BEEF, mis);
    chk("st_half_misalign", 32'(mis), 32'd0);
    do_load(32'h10, 2'b10, 1'b0, rd, rv, mis);
    chk("ld_word_10", rd, 32'hBEEFAA44);
    cyc();
    chk("rvalid_pulse", 32'(bus.mem_rvalid), 32'd0);
    chk("rdata_hold", bus.mem_rdata, 32'hBEEFAA44);
    do_load(32'h11, 2'b00, 1'b0, rd, rv, mis);
    chk("ld_sbyte_11", rd, 32'hFFFFFFAA);
    do_load(32'h11, 2'b00, 1'b1, rd, rv, mis);
    chk("ld_ubyte_11", rd, 32'h000000AA);
    do_load(32'h12, 2'b01, 1'b0, rd, rv, mis);
    chk("ld_shalf_12", rd, 32'hFFFFBEEF);
    do_load(32'h10, 2'b01, 1'b1, rd, rv, mis);
    chk("ld_uhalf_10", rd, 32'h0000AA44);
    do_load(32'h10, 2'b00, 1'b0, rd, rv, mis);
    chk("ld_sbyte_10", rd, 32'h00000044);

    do_store(32'h21, 2'b10, 32'hDEADBEEF, mis);
    chk("st_mis_flag", 32'(mis), 32'd1);
    do_load(32'h20, 2'b10, 1'b0, rd, rv, mis);
    chk("st_mis_nowrite", rd, 32'h0);
    chk("ld_ok_nomis", 32'(mis), 32'd0);
    do_load(32'h13, 2'b01, 1'b0, rd, rv, mis);
    chk("ld_mis_rvalid", 32'(rv), 32'd1);
    chk("ld_mis_rdata", rd, 32'h0);
    chk("ld_mis_flag", 32'(mis), 32'd1);
    do_load(32'h10, 2'b11, 1'b0, rd, rv, mis);
    chk("ld_rsvd_flag", 32'(mis), 32'd1);

    bus.mem_write = 1'b1;
    bus.mem_read  = 1'b1;
    bus.mem_addr  = 32'h30;
    bus.mem_size  = 2'b10;
    bus.mem_wdata = 32'hCAFEF00D;
    cyc();
    idle_in();
    $display("write+read addr=00000030 rvalid=%0b", bus.mem_rvalid);
    chk("wr_prio_norvalid", 32'(bus.mem_rvalid), 32'd0);
    do_load(32'h30, 2'b10, 1'b0, rd, rv, mis);
    chk("wr_prio_data", rd, 32'hCAFEF00D);

    do_store(32'h34, 2'b10, 32'h01020304, mis);
    do_load(32'h34, 2'b10, 1'b0, rd, rv, mis);
    chk("raw_data", rd, 32'h01020304);
    chk("raw_rvalid", 32'(rv), 32'd1);
    cyc();
    chk("raw_rvalid_off", 32'(bus.mem_rvalid), 32'd0);

    do_store(32'(4 * DEPTH), 2'b10, 32'h12345678, mis);
    do_load(32'h0, 2'b10, 1'b0, rd, rv, mis);
    chk("wrap_data", rd, 32'h12345678);

    bus.mem_write = 1'b1;
    bus.mem_addr  = 32'h40;
    bus.mem_size  = 2'b10;
    bus.mem_wdata = 32'h5;
    bus.clr_req   = 1'b1;
    cyc();
    idle_in();
    $display("store+clr_req addr=00000040 busy=%0b", bus.busy);
    chk("clr_busy", 32'(bus.busy), 32'd1);
    count_busy(1'b1, n, strobe);
    chk("clr_len", 32'(n), 32'(DEPTH));
    chk("clr_no_strobe", 32'(strobe), 32'd0);
    do_load(32'h40, 2'b10, 1'b0, rd, rv, mis);
    chk("clr_data_40", rd, 32'h0);
    do_load(32'h34, 2'b10, 1'b0, rd, rv, mis);
    chk("clr_data_34", rd, 32'h0);

    do_store(32'h8, 2'b10, 32'h77, mis);
    do_load(32'h8, 2'b10, 1'b0, rd, rv, mis);
    chk("pre_rst_data", rd, 32'h77);
    bus.clr_req = 1'b1;
    cyc();
    idle_in();
    repeat (DEPTH / 2) cyc();
    rst = 1'b0;
    #1;
    $display("reset asserted mid-clear rdata=%h busy=%0b", bus.mem_rdata, bus.busy);
    chk("midrst_rdata", bus.mem_rdata, 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'd1);
    chk("midrst_rvalid", 32'(bus.mem_rvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    count_busy(1'b0, n, strobe);
    chk("midrst_clear_len", 32'(n), 32'(DEPTH));
    do_load(32'h8, 2'b10, 1'b0, rd, rv, mis);
    chk("midrst_data_8", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_sized.md
Name: dmem_sized

Overview:
- Parametrised, depth-configurable data memory for the core's MEM stage.
- Supports byte, half-word and word accesses, with sign or zero extension on loads.
- Flags misaligned accesses.
- A hardware clear sequencer zeroes the array after reset or on request, one word per cycle.
- Registered read data (1-cycle latency) with a valid strobe.

Parameters:
- ADDR_WIDTH, 32, width of byte address mem_addr.
- DEPTH, 1024, number of 32-bit words; power of two, >=2. AW = log2(DEPTH).
- WORD_WIDTH, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_write  in  1  store request.
- mem_read  in  1  load request.
- mem_addr  in  ADDR_WIDTH  byte address. Word index = mem_addr[AW+1:2]; upper bits ignored (wrap modulo DEPTH).
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_unsigned  in  1  load extension: 1 zero-extend, 0 sign-extend.
- mem_wdata  in  WORD_WIDTH  store data, right-aligned.
- mem_rdata  out  WORD_WIDTH  registered load result.
- mem_rvalid  out  1  one-cycle pulse, mem_rdata updated this cycle.
- mem_misalign  out  1  one-cycle pulse, previous accepted access misaligned or reserved size.
- clr_req  in  1  start clear of whole array.
- busy  out  1  clear sequencer active; accesses ignored.

Behaviour:
- Reset (rst=0, async):
  - mem_rdata=0, mem_rvalid=0, mem_misalign=0, busy=1.
  - FSM forced to CLEAR, clear counter=0.
  - Array is not touched while rst=0.
- FSM states:
  - CLEAR: each cycle writes 0 to word[counter], counter++. When counter==DEPTH-1 is written, go to IDLE; busy=0 from the next cycle. One full clear = DEPTH cycles after rst release.
  - IDLE: accesses accepted. clr_req=1 -> CLEAR with counter=0 next cycle; busy=1 from that cycle. The access presented in the same cycle as clr_req is still performed.
- Clear-state rules:
  - clr_req during CLEAR is ignored; the clear does not restart.
  - mem_read/mem_write during CLEAR: no array change, no rvalid, no misalign.
- Reset mid-clear or mid-access: async abort, counter restarts at 0 after release.
- Access acceptance (IDLE only):
  - mem_write has priority; when both mem_write and mem_read are 1, the write is performed, no read response, no rvalid.
- Alignment:
  - Misaligned if (size=01 and addr[0]=1), or (size=10 and addr[1:0]!=0), or size=11.
- Store, aligned:
  - Byte: wdata[7:0] -> lane addr[1:0].
  - Half: wdata[15:0] -> lanes {addr[1],0}/{addr[1],1}.
  - Word: all lanes.
  - Unaddressed lanes unchanged.
- Store, misaligned: array unchanged; mem_misalign=1 next cycle.
- Load, aligned: next cycle mem_rvalid=1 and mem_rdata =
  - Byte: lane addr[1:0], extended to 32 bits.
  - Half: lanes per addr[1], extended to 32 bits.
  - Word: full word.
- Load, misaligned: next cycle mem_rvalid=1, mem_rdata=0, mem_misalign=1.
- mem_rdata holds its value until the next load response; rvalid and misalign are single-cycle pulses.
- Store followed by load of the same word on the next cycle returns the new data; no stale read.
- Back-to-back loads produce one response per cycle.

Test Plan:
- Reset then clear: release rst, keep idle -> busy=1 for exactly DEPTH cycles, then 0. Loads of word 0 and word DEPTH-1 return 0x00000000.
- Sized stores/loads: word store 0x11223344 @0x10; byte store 0xAA @0x11; half store 0xBEEF @0x12. Then:
  - word load @0x10 -> 0xBEEFAA44.
  - signed byte @0x11 -> 0xFFFFFFAA.
  - unsigned byte @0x11 -> 0x000000AA.
  - signed half @0x12 -> 0xFFFFBEEF.
- Misalignment: word store 0xDEADBEEF @0x21 -> misalign pulse next cycle, word @0x20 unchanged. Half load @0x13 -> rvalid=1, rdata=0, misalign=1.
- Priority and timing: write+read same cycle @0x30 -> no rvalid, store done. Store @0x34 then load @0x34 next cycle -> new data, rvalid exactly 1 cycle. Wrap: store @(4*DEPTH) -> visible @0x0.
- clr_req with concurrent store: store 0x5 @0x40 plus clr_req -> busy next cycle; loads during busy produce no rvalid; after DEPTH cycles load @0x40 -> 0.
- Reset mid-clear: assert rst at counter DEPTH/2 -> outputs zero immediately; after release busy lasts a full DEPTH cycles.
